tinyqv_uart_tx_periph: RTL and testbench

// - Memory-mapped UART transmitter on tinyQV's non-memory data transaction port (data_addr[27:25] != 0).
// - Decodes a 16-byte register window, buffers TX bytes in a small FIFO, serialises 8N1 frames.
// - Drives a level interrupt into interrupt_req[15:2].

---
 rtl/tinyqv_periph_pkg.sv | 21 ++
 rtl/tinyqv_uart_tx_periph_if.sv | 19 +
 rtl/tinyqv_uart_tx_core.sv | 86 ++++++++
 rtl/tinyqv_uart_tx_periph.sv | 144 ++++++++++++++
 tb/tb_tinyqv_uart_tx_periph.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinyqv_periph_pkg.sv
// Shared constants for tinyQV peripherals: register offsets, transaction sizes, UART FSM states.
package tinyqv_periph_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVIDER = 2'd2;
    localparam logic [1:0] REG_IRQ_EN  = 2'd3;

    localparam logic [1:0] SZ_NONE = 2'b11;
    localparam logic [1:0] SZ_8    = 2'b00;
    localparam logic [1:0] SZ_16   = 2'b01;
    localparam logic [1:0] SZ_32   = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/tinyqv_uart_tx_periph_if.sv
// tinyQV non-memory data transaction port; the CPU is master, the peripheral is slave.
interface tinyqv_uart_tx_periph_if;
    logic [27:0] data_addr;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic [31:0] data_in;

    modport master (
        output data_addr, data_write_n, data_read_n, data_out,
        input  data_ready, data_in
    );

    modport slave (
        input  data_addr, data_write_n, data_read_n, data_out,
        output data_ready, data_in
    );
endinterface

// File: rtl/tinyqv_uart_tx_core.sv
// 8N1 serialiser: bit-period counter, shift register and start/data/stop FSM.
module tinyqv_uart_tx_core
    import tinyqv_periph_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           byte_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 uart_tx_o,
    output logic                 busy_o
);

    uart_state_e          state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tick;
    logic                 take;

    assign tick    = (cnt_q == '0);
    // A new byte can be taken while idle or on the last clock of a stop bit.
    assign ready_o = (state_q == StIdle) || ((state_q == StStop) && tick);
    assign take    = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (state_q != StIdle) begin
            cnt_d = tick ? div_i : cnt_q - 1'b1;
        end
        case (state_q)
            StIdle:  state_d = StIdle;
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (take) begin
            state_d = StStart;
            shift_d = byte_i;
            cnt_d   = div_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign uart_tx_o = (state_q == StStart) ? 1'b0 :
                       (state_q == StData)  ? shift_q[0] : 1'b1;
    assign busy_o    = (state_q != StIdle);

endmodule

// File: rtl/tinyqv_uart_tx_periph.sv
// Memory-mapped UART transmitter: register decode, TX FIFO and serialiser.
// Define TINYQV_UART_CTS_EN to add the uart_cts_n_i flow-control input.
module tinyqv_uart_tx_periph
    import tinyqv_periph_pkg::*;
#(
    parameter logic [27:0]          BASE_ADDR  = 28'h800_0040,
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter int unsigned          DIV_WIDTH  = 12,
    parameter logic [DIV_WIDTH-1:0] RESET_DIV  = 12'd103
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    tinyqv_uart_tx_periph_if.slave  bus,
`ifdef TINYQV_UART_CTS_EN
    input  logic                    uart_cts_n_i,
`endif
    output logic                    uart_tx_o,
    output logic                    irq_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);

    logic                 is_wr, is_rd, sel, tx_wr;
    logic [1:0]           offset;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]      level_q;
    logic                 full, empty, push, pop;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 irq_en_q, irq_en_d;
    logic                 cts_ok, core_ready, core_busy;
    logic [31:0]          status, rdata;
    logic                 unused_bits;

    assign is_wr  = (bus.data_write_n != SZ_NONE);
    assign is_rd  = (bus.data_read_n != SZ_NONE);
    assign sel    = (bus.data_addr[27:4] == BASE_ADDR[27:4]) && (is_wr || is_rd);
    assign offset = bus.data_addr[3:2];
    assign tx_wr  = sel && is_wr && (offset == REG_TXDATA);

    assign full  = (level_q == LvlW'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign pop   = !empty && cts_ok && core_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = tx_wr && (!full || pop);
    assign bus.data_ready = sel && (!tx_wr || !full || pop);

`ifdef TINYQV_UART_CTS_EN
    logic [1:0] cts_sync_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cts_sync_q <= 2'b11;
        end else begin
            cts_sync_q <= {cts_sync_q[0], uart_cts_n_i};
        end
    end
    assign cts_ok = !cts_sync_q[1];
`else
    assign cts_ok = 1'b1;
`endif

    always_comb begin
        div_d    = div_q;
        irq_en_d = irq_en_q;
        if (sel && is_wr) begin
            if (offset == REG_DIVIDER) begin
                if (bus.data_write_n == SZ_8) begin
                    div_d[7:0] = bus.data_out[7:0];
                end else begin
                    div_d = bus.data_out[DIV_WIDTH-1:0];
                end
            end
            if (offset == REG_IRQ_EN) begin
                irq_en_d = bus.data_out[0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            div_q    <= RESET_DIV;
            irq_en_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
            div_q    <= div_d;
            irq_en_q <= irq_en_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data_out[7:0];
        end
    end

    always_comb begin
        status              = 32'd0;
        status[0]           = !empty || core_busy;
        status[1]           = full;
        status[2]           = empty;
        status[4 +: LvlW]   = level_q;
        rdata               = 32'd0;
        if (sel && is_rd) begin
            case (offset)
                REG_STATUS:  rdata = status;
                REG_DIVIDER: rdata = 32'(div_q);
                REG_IRQ_EN:  rdata = {31'd0, irq_en_q};
                default:     rdata = 32'd0;
            endcase
        end
    end
    assign bus.data_in = rdata;

    tinyqv_uart_tx_core #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_core (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .byte_i    (mem_q[rd_ptr_q]),
        .valid_i   (!empty && cts_ok),
        .ready_o   (core_ready),
        .div_i     (div_q),
        .uart_tx_o (uart_tx_o),
        .busy_o    (core_busy)
    );

    assign irq_o       = irq_en_q && empty && !core_busy;
    assign unused_bits = ^{bus.data_addr[1:0], bus.data_out[31:8]};

endmodule

// File: tb/tb_tinyqv_uart_tx_periph.sv
// Directed bench: register-access vector table plus hand-written serial-timing sequences.
module tb_tinyqv_uart_tx_periph;
    import tinyqv_periph_pkg::*;

    localparam logic [27:0] Base = 28'h800_0040;

    typedef struct {
        logic        is_wr;
        logic [27:0] addr;
        logic [1:0]  sz;
        logic [31:0] wdata;
        logic        exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx, irq;
`ifdef TINYQV_UART_CTS_EN
    logic cts_n = 1'b0;
`endif

    tinyqv_uart_tx_periph_if bus ();

    tinyqv_uart_tx_periph dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
`ifdef TINYQV_UART_CTS_EN
        .uart_cts_n_i (cts_n),
`endif
        .uart_tx_o    (uart_tx),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];
    logic rec = 1'b0;
    logic tx_log[$];
    logic irq_log[$];

    always @(negedge clk) begin
        if (rec) begin
            tx_log.push_back(uart_tx);
            irq_log.push_back(irq);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.data_addr    = 28'd0;
        bus.data_write_n = SZ_NONE;
        bus.data_read_n  = SZ_NONE;
        bus.data_out     = 32'd0;
    endtask

    task automatic drive(input logic w, input logic [27:0] a, input logic [1:0] sz,
                         input logic [31:0] wd);
        bus.data_addr    = a;
        bus.data_write_n = w ? sz : SZ_NONE;
        bus.data_read_n  = w ? SZ_NONE : sz;
        bus.data_out     = wd;
    endtask

    // Starts just after a rising edge; returns just after the edge that took the write.
    task automatic wr(input logic [3:0] off, input logic [31:0] wd, input logic [1:0] sz,
                      output int stalls);
        drive(1'b1, Base | 28'(off), sz, wd);
        stalls = 0;
        @(negedge clk);
        while (!bus.data_ready && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (!bus.data_ready) check("write_timeout", 32'(bus.data_ready), 32'd1);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        drive(1'b0, Base | 28'(off), SZ_32, 32'd0);
        @(negedge clk);
        d = bus.data_in;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic add(input logic w, input logic [27:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input logic er, input logic [31:0] ed);
        vec_t v;
        v.is_wr = w; v.addr = a; v.sz = sz; v.wdata = wd; v.exp_ready = er; v.exp_rdata = ed;
        vecs.push_back(v);
    endtask

    initial begin
        int          s;
        logic [31:0] d;
        logic [9:0]  frame, cap;
        logic [7:0]  bytes [6];
        int          first_irq;

        bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'hC3;
        bytes[3] = 8'h5A; bytes[4] = 8'hFF; bytes[5] = 8'h00;

        add(0, Base | 28'h4,  SZ_32,   32'h0,         1, 32'h4);
        add(0, Base | 28'h8,  SZ_32,   32'h0,         1, 32'd103);
        add(0, Base | 28'hC,  SZ_32,   32'h0,         1, 32'h0);
        add(0, Base | 28'h0,  SZ_32,   32'h0,         1, 32'h0);
        add(0, Base + 28'h10, SZ_32,   32'h0,         0, 32'h0);
        add(0, Base | 28'h4,  SZ_NONE, 32'h0,         0, 32'h0);
        add(1, Base | 28'h8,  SZ_32,   32'hFFFF_F123, 1, 32'h0);
        add(0, Base | 28'h8,  SZ_32,   32'h0,         1, 32'h123);
        add(1, Base | 28'h8,  SZ_8,    32'hFFFF_FF45, 1, 32'h0);
        add(0, Base | 28'hA,  SZ_8,    32'h0,         1, 32'h145);
        add(1, Base | 28'h9,  SZ_16,   32'h0000_0A0B, 1, 32'h0);
        add(0, Base | 28'h8,  SZ_32,   32'h0,         1, 32'hA0B);
        add(1, Base | 28'h4,  SZ_32,   32'hFFFF_FFFF, 1, 32'h0);
        add(0, Base | 28'h4,  SZ_32,   32'h0,         1, 32'h4);
        add(1, Base + 28'h18, SZ_32,   32'h3,         0, 32'h0);
        add(0, Base | 28'h8,  SZ_32,   32'h0,         1, 32'hA0B);
        add(1, Base | 28'hC,  SZ_32,   32'hFFFF_FFFE, 1, 32'h0);
        add(0, Base | 28'hC,  SZ_32,   32'h0,         1, 32'h0);
        add(1, Base | 28'hC,  SZ_32,   32'h1,         1, 32'h0);
        add(0, Base | 28'hF,  SZ_8,    32'h0,         1, 32'h1);
        add(1, Base | 28'hC,  SZ_32,   32'h0,         1, 32'h0);
        add(0, Base | 28'hC,  SZ_32,   32'h0,         1, 32'h0);

        idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_tx", 32'(uart_tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].is_wr, vecs[i].addr, vecs[i].sz, vecs[i].wdata);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 32'(bus.data_ready), 32'(vecs[i].exp_ready));
            if (!vecs[i].is_wr) check($sformatf("vec%0d_rdata", i), bus.data_in, vecs[i].exp_rdata);
            @(posedge clk);
            #1;
            idle();
        end

        // Single 0xA5 frame at 4 clocks per bit, STATUS held on the bus throughout.
        wr(4'h8, 32'd3, SZ_32, s);
        wr(4'hC, 32'd1, SZ_32, s);
        check("irq_idle_enabled", 32'(irq), 32'd1);
        wr(4'h0, 32'hA5, SZ_8, s);
        frame = {1'b1, 8'hA5, 1'b0};
        drive(1'b0, Base | 28'h4, SZ_32, 32'd0);
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            check($sformatf("a5_tx_c%0d", i), 32'(uart_tx),
                  (i == 0 || i == 41) ? 32'd1 : 32'(frame[(i - 1) / 4]));
            check($sformatf("a5_status_c%0d", i), bus.data_in,
                  (i == 0) ? 32'h11 : (i == 41) ? 32'h4 : 32'h5);
            check($sformatf("a5_irq_c%0d", i), 32'(irq), (i == 41) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        idle();

        // DIVIDER = 0: the first byte goes straight to the shifter, so the sixth write meets a
        // full FIFO and waits for the stop-bit pop of frame 0.
        wr(4'h8, 32'd0, SZ_32, s);
        rec = 1'b1;
        for (int b = 0; b < 6; b++) begin
            wr(4'h0, 32'(bytes[b]), SZ_8, s);
            check($sformatf("b2b_stalls_w%0d", b), 32'(s), (b == 5) ? 32'd6 : 32'd0);
        end
        rd(4'h4, d);
        check("b2b_status_full", d, 32'h43);
        repeat (55) @(posedge clk);
        #1;
        rec = 1'b0;
        check("b2b_log_len", 32'(tx_log.size() >= 63), 32'd1);
        if (tx_log.size() >= 63) begin
            check("b2b_pre_start_tx", 32'(tx_log[1]), 32'd1);
            for (int f = 0; f < 6; f++) begin
                for (int k = 0; k < 10; k++) cap[k] = tx_log[2 + 10 * f + k];
                check($sformatf("b2b_frame%0d", f), 32'(cap), 32'({1'b1, bytes[f], 1'b0}));
            end
            check("b2b_post_idle_tx", 32'(tx_log[62]), 32'd1);
            check("b2b_irq_before_push", 32'(irq_log[0]), 32'd1);
            check("b2b_irq_after_push", 32'(irq_log[1]), 32'd0);
            first_irq = -1;
            for (int i = 1; i < irq_log.size(); i++) begin
                if (irq_log[i] && first_irq < 0) first_irq = i;
            end
            check("b2b_irq_rise_cycle", 32'(first_irq), 32'd62);
        end

        // Reset during data bit 3 of 0xF7 with 0x33 still queued.
        wr(4'h8, 32'd3, SZ_32, s);
        wr(4'h0, 32'hF7, SZ_8, s);
        wr(4'h0, 32'h33, SZ_8, s);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_bit3_tx", 32'(uart_tx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_tx_high", 32'(uart_tx), 32'd1);
        check("rst_irq_low", 32'(irq), 32'd0);
        rd(4'h4, d);
        check("rst_status", d, 32'h4);
        rd(4'h8, d);
        check("rst_divider", d, 32'd103);
        rd(4'hC, d);
        check("rst_irq_en", d, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rst_no_resume_c%0d", i), 32'(uart_tx), 32'd1);
        end
        @(posedge clk);
        #1;

`ifdef TINYQV_UART_CTS_EN
        cts_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wr(4'h0, 32'h55, SZ_8, s);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("cts_held_c%0d", i), 32'(uart_tx), 32'd1);
        end
        @(posedge clk);
        #1;
        cts_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("cts_release_c%0d", i), 32'(uart_tx), (i == 3) ? 32'd0 : 32'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
